// File: rtl/mem_bus_target.sv
// Byte-wide memory-bus target: registered-read RAM plus an I/O window with UART TX/RX FIFOs.
// Optional build macro MEM_TARGET_HALT_EN enables the program_halt register at 0x30004.
module mem_bus_target #(
    parameter int ADDR_BITS   = 17,
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        mem_rw,
    input  logic [31:0] mem_aout,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        tx_overflow,
    output logic        program_halt
);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int TX_THR_I = TX_DEPTH - FULL_MARGIN;
    localparam logic [TXA:0] TX_CNT_MAX = TX_DEPTH[TXA:0];
    localparam logic [TXA:0] TX_THR     = TX_THR_I[TXA:0];
    localparam logic [RXA:0] RX_CNT_MAX = RX_DEPTH[RXA:0];

    logic [7:0] ram [2**ADDR_BITS];
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];

    logic [TXA-1:0] tx_wr, tx_rd;
    logic [TXA:0]   tx_count, tx_count_next;
    logic [RXA-1:0] rx_wr, rx_rd;
    logic [RXA:0]   rx_count, rx_count_next;

    logic                 acc, is_io, io_data, io_stat;
    logic [ADDR_BITS-1:0] idx;
    logic                 tx_full, tx_req, tx_push, tx_pop;
    logic                 rx_empty, rx_push, rx_pop;
    logic                 unused_aout;

    // Only bits [17:0] take part in decode; the rest of the bus address is don't-care.
    assign unused_aout = ^mem_aout[31:18];

    assign acc     = rdy_in & ~rst_in;
    assign is_io   = (mem_aout[17:16] == 2'b11);
    assign io_data = (mem_aout[17:0] == 18'h30000);
    assign io_stat = (mem_aout[17:0] == 18'h30004);
    assign idx     = mem_aout[ADDR_BITS-1:0];

    assign tx_full  = (tx_count == TX_CNT_MAX);
    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_mem[tx_rd];
    assign tx_req   = acc & is_io & mem_rw & io_data;
    // UART side drains independently of rdy_in; a same-cycle pop frees the slot for a push.
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_push  = tx_req & (~tx_full | tx_pop);

    assign rx_empty = (rx_count == '0);
    assign rx_ready = (rx_count != RX_CNT_MAX);
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = acc & is_io & ~mem_rw & io_data & ~rx_empty;

    always_comb begin
        tx_count_next = tx_count;
        if (tx_push && !tx_pop)
            tx_count_next = tx_count + 1'b1;
        else if (!tx_push && tx_pop)
            tx_count_next = tx_count - 1'b1;
    end

    always_comb begin
        rx_count_next = rx_count;
        if (rx_push && !rx_pop)
            rx_count_next = rx_count + 1'b1;
        else if (!rx_push && rx_pop)
            rx_count_next = rx_count - 1'b1;
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (acc && mem_rw && !is_io)
            ram[idx] <= mem_dout;
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr] <= mem_dout;
        if (rx_push && !rst_in)
            rx_mem[rx_wr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            tx_wr          <= '0;
            tx_rd          <= '0;
            tx_count       <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            if (tx_push)
                tx_wr <= tx_wr + 1'b1;
            if (tx_pop)
                tx_rd <= tx_rd + 1'b1;
            tx_count       <= tx_count_next;
            io_buffer_full <= (tx_count_next >= TX_THR);
            if (tx_req && tx_full && !tx_pop)
                tx_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push)
                rx_wr <= rx_wr + 1'b1;
            if (rx_pop)
                rx_rd <= rx_rd + 1'b1;
            rx_count <= rx_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            mem_din <= 8'h00;
        end else if (rdy_in) begin
            if (mem_rw)
                mem_din <= 8'h00;
            else if (is_io) begin
                if (io_data)
                    mem_din <= rx_empty ? 8'h00 : rx_mem[rx_rd];
                else if (io_stat)
                    mem_din <= {7'b0, ~rx_empty};
                else
                    mem_din <= 8'h00;
            end else
                mem_din <= ram[idx];
        end
    end

`ifdef MEM_TARGET_HALT_EN
    logic halt_q;

    always_ff @(posedge clk) begin
        if (rst_in)
            halt_q <= 1'b0;
        else if (acc && is_io && mem_rw && io_stat)
            halt_q <= 1'b1;
    end

    assign program_halt = halt_q;

`ifndef SYNTHESIS
    // Let the UART flush everything already queued before ending the simulation.
    always @(posedge clk) begin
        if (halt_q && tx_count == '0)
            $finish;
    end
`endif
`else
    assign program_halt = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_target.sv
// Directed bench for mem_bus_target: read data and TX bytes are checked by scoreboard monitors.
module tb_mem_bus_target;
    logic        clk = 1'b0;
    logic        rst_in, rdy_in, mem_rw;
    logic [31:0] mem_aout;
    logic [7:0]  mem_dout, mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic        tx_overflow, program_halt;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic       chk_rd = 1'b0;
    logic       rd_tag = 1'b0;

    mem_bus_target dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .mem_rw(mem_rw),
        .mem_aout(mem_aout), .mem_dout(mem_dout), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_overflow(tx_overflow), .program_halt(program_halt)
    );

    always #5 clk = ~clk;

    // A read sampled at this edge must show up on mem_din before the next edge.
    always @(posedge clk) rd_tag <= chk_rd && rdy_in && !rst_in;

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rd_tag) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: mem_din=%02h with empty expected queue", mem_din);
            end else begin
                e = exp_q.pop_front();
                if (mem_din !== e) begin
                    bad++;
                    $display("FAIL rd_data: got %02h want %02h", mem_din, e);
                end
            end
        end
        if (tx_valid && tx_ready && !rst_in) begin
            total++;
            if (tx_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: tx_data=%02h with empty expected queue", tx_data);
            end else begin
                e = tx_q.pop_front();
                if (tx_data !== e) begin
                    bad++;
                    $display("FAIL tx_data: got %02h want %02h", tx_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        mem_rw = 1'b0; mem_aout = 32'h0; chk_rd = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        mem_rw = 1'b1; mem_aout = a; mem_dout = d; chk_rd = 1'b0;
        tick();
        mem_rw = 1'b0; mem_aout = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [7:0] e);
        mem_rw = 1'b0; mem_aout = a; chk_rd = 1'b1;
        exp_q.push_back(e);
        tick();
        chk_rd = 1'b0; mem_aout = 32'h0;
    endtask

    task automatic tx_write(input logic [7:0] d, input bit accepted);
        if (accepted) tx_q.push_back(d);
        bus_write(32'h30000, d);
    endtask

    task automatic rx_send(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        bus_idle();
        rx_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_in = 1'b1;
        bus_idle();
        rst_in = 1'b0;
        tx_q.delete();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; mem_rw = 1'b0; mem_aout = 32'h0; mem_dout = 8'h0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
        tick(); tick();
        rst_in = 1'b0;
        check("rst_mem_din", {24'h0, mem_din}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        check("rst_overflow", {31'h0, tx_overflow}, 32'h0);
        check("rst_halt", {31'h0, program_halt}, 32'h0);

        // Write then immediately read the same byte; upper address bits are ignored.
        bus_write(32'h0000_0010, 8'hA5);
        bus_read(32'h0000_0010, 8'hA5);
        bus_read(32'hFF00_0010, 8'hA5);

        // Stall: no RAM write and mem_din holds.
        rdy_in = 1'b0;
        bus_write(32'h0000_0010, 8'h77);
        check("stall_hold", {24'h0, mem_din}, 32'hA5);
        rdy_in = 1'b1;
        bus_read(32'h0000_0010, 8'hA5);

        bus_write(32'h100, 8'h11);
        bus_write(32'h101, 8'h22);
        bus_write(32'h102, 8'h33);
        bus_write(32'h103, 8'h44);
        bus_read(32'h100, 8'h11);
        bus_read(32'h101, 8'h22);
        bus_read(32'h102, 8'h33);
        bus_read(32'h103, 8'h44);

        // Fill TX with the UART stalled, then overflow.
        for (int i = 1; i <= 5; i++) tx_write(8'(i), 1'b1);
        check("full_after5", {31'h0, io_buffer_full}, 32'h0);
        tx_write(8'h06, 1'b1);
        check("full_after6", {31'h0, io_buffer_full}, 32'h1);
        tx_write(8'h07, 1'b1);
        tx_write(8'h08, 1'b1);
        check("ovf_after8", {31'h0, tx_overflow}, 32'h0);
        tx_write(8'h09, 1'b0);
        check("ovf_after9", {31'h0, tx_overflow}, 32'h1);

        reset_pulse();
        check("ovf_cleared", {31'h0, tx_overflow}, 32'h0);

        // Full FIFO with a simultaneous pop and push: nothing dropped, new byte at the tail.
        for (int i = 0; i < 8; i++) tx_write(8'h11 + 8'(i), 1'b1);
        tx_ready = 1'b1;
        tx_write(8'h19, 1'b1);
        check("simul_ovf", {31'h0, tx_overflow}, 32'h0);
        check("simul_full", {31'h0, io_buffer_full}, 32'h1);
        for (int i = 0; i < 8; i++) bus_idle();
        tx_ready = 1'b0;
        check("drained_valid", {31'h0, tx_valid}, 32'h0);
        check("drained_q", tx_q.size(), 32'h0);

        // RX path.
        rx_send(8'h41);
        rx_send(8'h42);
        bus_read(32'h30004, 8'h01);
        bus_read(32'h30000, 8'h41);
        bus_read(32'h30000, 8'h42);
        bus_read(32'h30000, 8'h00);
        bus_read(32'h30004, 8'h00);
        bus_read(32'h30008, 8'h00);
        rx_send(8'h61);
        rx_send(8'h62);
        rx_send(8'h63);
        check("rx_ready_3", {31'h0, rx_ready}, 32'h1);
        rx_send(8'h64);
        check("rx_ready_4", {31'h0, rx_ready}, 32'h0);
        rx_send(8'h65);
        bus_read(32'h30000, 8'h61);
        bus_read(32'h30000, 8'h62);
        bus_read(32'h30000, 8'h63);
        bus_read(32'h30000, 8'h64);
        bus_read(32'h30000, 8'h00);
        check("rx_ready_empty", {31'h0, rx_ready}, 32'h1);

        // Reset mid-stream with bytes queued; RAM must survive.
        tx_write(8'hC1, 1'b1);
        tx_write(8'hC2, 1'b1);
        tx_write(8'hC3, 1'b1);
        bus_read(32'h10, 8'hA5);
        check("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
        reset_pulse();
        check("post_rst_valid", {31'h0, tx_valid}, 32'h0);
        check("post_rst_full", {31'h0, io_buffer_full}, 32'h0);
        check("post_rst_din", {24'h0, mem_din}, 32'h0);
        bus_read(32'h10, 8'hA5);

        bus_idle();
        bus_idle();
        check("rd_q_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
